// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the command frame parser: FSM states,
// opcodes, default header bytes and the frame checksum.
package cmd_frame_pkg;

  typedef enum logic [2:0] {
    S_H0   = 3'd0,
    S_H1   = 3'd1,
    S_CMD  = 3'd2,
    S_CHK  = 3'd3,
    S_EXEC = 3'd4
  } state_e;

  localparam logic [7:0] CMD_SEL_A = 8'h01;
  localparam logic [7:0] CMD_SEL_B = 8'h02;
  localparam logic [7:0] CMD_AUTO  = 8'h03;
  localparam logic [7:0] CMD_RST_A = 8'h10;
  localparam logic [7:0] CMD_RST_B = 8'h11;

  localparam logic [7:0] HDR0_DEF = 8'hEB;
  localparam logic [7:0] HDR1_DEF = 8'h90;

  function automatic logic [7:0] frame_chk(input logic [7:0] h0,
                                           input logic [7:0] h1,
                                           input logic [7:0] cmd);
    logic [7:0] sum;
    sum = h0 + h1 + cmd;
    return sum;
  endfunction

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_SEL_A) || (cmd == CMD_SEL_B) || (cmd == CMD_AUTO) ||
           (cmd == CMD_RST_A) || (cmd == CMD_RST_B);
  endfunction

endpackage

// File: rtl/cmd_pulse_gen.sv
// Reset pulse generator: one shared down-counter drives reset_A/reset_B for
// RST_PULSE_CYC cycles after a load; a new load restarts it and ORs in the line.
module cmd_pulse_gen #(
  parameter int RST_PULSE_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_a_i,
  input  logic load_b_i,
  output logic reset_a_o,
  output logic reset_b_o
);

  localparam int CW = $clog2(RST_PULSE_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(RST_PULSE_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_a_q, sel_a_d;
  logic          sel_b_q, sel_b_d;
  logic          active;

  assign active = (cnt_q != '0);

  always_comb begin
    cnt_d   = cnt_q;
    sel_a_d = (sel_a_q & active) | load_a_i;
    sel_b_d = (sel_b_q & active) | load_b_i;
    if (load_a_i || load_b_i) begin
      cnt_d = LOAD_VAL;
    end else if (active) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sel_a_q <= 1'b0;
      sel_b_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign reset_a_o = sel_a_q & active;
  assign reset_b_o = sel_b_q & active;

endmodule

// File: rtl/cmd_frame_parser.sv
// Command frame parser: drains the command RX FIFO, validates HDR0 HDR1 CMD CHK
// frames and drives switch/reset controls. Define CMD_FRAME_ECHO_EN to echo frames.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int         FIFO_CW       = 5,
  parameter int         RST_PULSE_CYC = 1000,
  parameter logic [7:0] HDR0          = HDR0_DEF,
  parameter logic [7:0] HDR1          = HDR1_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rec_command,
  input  logic [FIFO_CW-1:0] com_count,
  input  logic               command_time_out,
  output logic               com_pop,
  output logic               force_swi,
  output logic               com_swi,
  output logic               error,
  output logic               reset_A,
  output logic               reset_B,
  output logic [7:0]         tdr_cpuAB,
  output logic               tf_push_cpuAB,
  output logic [7:0]         frame_err_cnt
);

  state_e     state_q, state_d;
  logic       pop_hold_q, pop_hold_d;
  logic [7:0] cmd_q, cmd_d;
  logic       force_q, force_d;
  logic       swi_q, swi_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       load_a, load_b;
  logic       bad_frame;
  logic       tmo_abort;
  logic       fetch_ok;
  logic       exec_last;

  // Timeout only aborts a frame already in progress and beats byte acceptance.
  assign tmo_abort = command_time_out &&
                     ((state_q == S_H1) || (state_q == S_CMD) || (state_q == S_CHK));
  assign fetch_ok  = (state_q != S_EXEC) && (com_count != '0) && !pop_hold_q && !tmo_abort;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    force_d   = force_q;
    swi_d     = swi_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    com_pop   = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    bad_frame = 1'b0;

    if (tmo_abort) begin
      state_d   = S_H0;
      bad_frame = 1'b1;
    end else if (fetch_ok) begin
      com_pop = 1'b1;
      case (state_q)
        S_H0: if (rec_command == HDR0) state_d = S_H1;
        S_H1: begin
          if (rec_command == HDR1)      state_d = S_CMD;
          else if (rec_command == HDR0) state_d = S_H1;
          else                          state_d = S_H0;
        end
        S_CMD: begin
          cmd_d   = rec_command;
          state_d = S_CHK;
        end
        S_CHK: begin
          if ((rec_command == frame_chk(HDR0, HDR1, cmd_q)) && cmd_known(cmd_q)) begin
            state_d = S_EXEC;
          end else begin
            state_d   = S_H0;
            bad_frame = 1'b1;
          end
        end
        default: state_d = S_H0;
      endcase
    end else if ((state_q == S_EXEC) && exec_last) begin
      state_d = S_H0;
      err_d   = 1'b0;
      case (cmd_q)
        CMD_SEL_A: begin force_d = 1'b1; swi_d = 1'b0; end
        CMD_SEL_B: begin force_d = 1'b1; swi_d = 1'b1; end
        CMD_AUTO:  begin force_d = 1'b0; swi_d = 1'b0; end
        CMD_RST_A: load_a = 1'b1;
        CMD_RST_B: load_b = 1'b1;
        default: ;
      endcase
    end

    if (bad_frame) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // One idle cycle after every pop lets the FIFO count/data catch up.
  assign pop_hold_d = com_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_H0;
      pop_hold_q <= 1'b0;
      cmd_q      <= '0;
      force_q    <= 1'b0;
      swi_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pop_hold_q <= pop_hold_d;
      cmd_q      <= cmd_d;
      force_q    <= force_d;
      swi_q      <= swi_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

`ifdef CMD_FRAME_ECHO_EN
  logic [2:0] echo_q, echo_d;
  logic [7:0] frame_q [4];

  assign echo_d        = (state_q == S_EXEC) ? echo_q + 3'd1 : 3'd0;
  assign exec_last     = (echo_q == 3'd7);
  assign tf_push_cpuAB = (state_q == S_EXEC) && !echo_q[0];
  assign tdr_cpuAB     = tf_push_cpuAB ? frame_q[echo_q[2:1]] : 8'h00;

  // Fetch states encode the frame slot in their low bits (H0=0 .. CHK=3).
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_q <= '0;
      for (int i = 0; i < 4; i++) frame_q[i] <= '0;
    end else begin
      echo_q <= echo_d;
      if (com_pop) frame_q[state_q[1:0]] <= rec_command;
    end
  end
`else
  assign exec_last     = 1'b1;
  assign tf_push_cpuAB = 1'b0;
  assign tdr_cpuAB     = 8'h00;
`endif

  cmd_pulse_gen #(
    .RST_PULSE_CYC(RST_PULSE_CYC)
  ) u_pulse (
    .clk       (clk),
    .rst       (rst),
    .load_a_i  (load_a),
    .load_b_i  (load_b),
    .reset_a_o (reset_A),
    .reset_b_o (reset_B)
  );

  assign force_swi     = force_q;
  assign com_swi       = swi_q;
  assign error         = err_q;
  assign frame_err_cnt = err_cnt_q;

endmodule
